// File: rtl/host_req_arbiter_pkg.sv
// Shared types and defaults for the host request arbiter.
package host_req_arbiter_pkg;

  localparam int N_HOST_ARB_SRC     = 4;
  localparam int HOST_ARB_MAX_OUTST = 8;

  typedef enum logic {ARB, SEND} host_arb_state_t;

  typedef logic [7:0] outst_cnt_t;

endpackage

// File: rtl/host_req_arbiter_rr_prio_sel.sv
// Round-robin priority select: first set bit of req at or after ptr, wrapping mod N.
module rr_prio_sel #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          gnt_valid,
  output logic [PW-1:0] gnt_idx
);

  int idx;

  // Walk the rotated order backwards so the lowest rotated position wins last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/host_req_arbiter.sv
// Round-robin host request arbiter with per-source credit limit and id tagging.
// Define HOST_ARB_STATS_EN to add per-source 32-bit grant counters (grant_cnt).
//
// state | meaning
// ARB   | pick an eligible source, capture its request, take a credit
// SEND  | hold captured request on m_req_* until downstream accepts
module host_req_arbiter
  import host_req_arbiter_pkg::*;
#(
  parameter  int N_SRC     = N_HOST_ARB_SRC,
  parameter  int REQ_BITS  = 128,
  parameter  int MAX_OUTST = HOST_ARB_MAX_OUTST,
  localparam int ID_BITS   = $clog2(N_SRC)
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [N_SRC-1:0]          s_req_valid,
  output logic [N_SRC-1:0]          s_req_ready,
  input  logic [N_SRC*REQ_BITS-1:0] s_req_data,
  output logic                      m_req_valid,
  input  logic                      m_req_ready,
  output logic [REQ_BITS-1:0]       m_req_data,
  output logic [ID_BITS-1:0]        m_req_id,
  input  logic                      cpl_valid,
  input  logic [ID_BITS-1:0]        cpl_id,
  output logic [N_SRC*8-1:0]        outst_cnt,
  output logic                      err_cpl
`ifdef HOST_ARB_STATS_EN
  ,
  output logic [N_SRC*32-1:0]       grant_cnt
`endif
);

  host_arb_state_t    state_q, state_d;
  logic [ID_BITS-1:0] rr_ptr_q;
  outst_cnt_t         outst_q [N_SRC];
  logic [N_SRC-1:0]   eligible;
  logic [N_SRC-1:0]   cpl_hit;
  logic [N_SRC-1:0]   cpl_dec;
  logic               cpl_bad;
  logic               gnt_valid;
  logic [ID_BITS-1:0] gnt_idx;
  logic               grant;

  rr_prio_sel #(.N(N_SRC), .PW(ID_BITS)) u_sel (
    .req       (eligible),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign grant       = (state_q == ARB) && gnt_valid;
  assign m_req_valid = (state_q == SEND);

  always_comb begin
    cpl_hit     = '0;
    cpl_dec     = '0;
    eligible    = '0;
    s_req_ready = '0;
    outst_cnt   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cpl_hit[i]          = cpl_valid && (int'(cpl_id) == i);
      cpl_dec[i]          = cpl_hit[i] && (outst_q[i] != '0);
      eligible[i]         = s_req_valid[i] && (outst_q[i] < outst_cnt_t'(MAX_OUTST));
      s_req_ready[i]      = grant && (int'(gnt_idx) == i);
      outst_cnt[i*8 +: 8] = outst_q[i];
    end
    // An id beyond N_SRC or a completion on an empty counter is a protocol error.
    cpl_bad = cpl_valid && ((int'(cpl_id) >= N_SRC) || (cpl_hit != cpl_dec));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB:  if (gnt_valid) state_d = SEND;
      SEND: if (m_req_ready) state_d = ARB;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      m_req_data <= '0;
      m_req_id   <= '0;
      err_cpl    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        m_req_data <= s_req_data[gnt_idx*REQ_BITS +: REQ_BITS];
        m_req_id   <= gnt_idx;
        rr_ptr_q   <= (int'(gnt_idx) == N_SRC - 1) ? '0 : gnt_idx + 1'b1;
      end
      if (cpl_bad) err_cpl <= 1'b1;
    end
  end

  // Grant and completion on the same id cancel out.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < N_SRC; i++) outst_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (s_req_ready[i] && !cpl_dec[i])
          outst_q[i] <= outst_q[i] + 1'b1;
        else if (!s_req_ready[i] && cpl_dec[i])
          outst_q[i] <= outst_q[i] - 1'b1;
      end
    end
  end

`ifdef HOST_ARB_STATS_EN
  logic [31:0] grant_q [N_SRC];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < N_SRC; i++) grant_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++)
        if (s_req_ready[i]) grant_q[i] <= grant_q[i] + 32'd1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_SRC; i++) grant_cnt[i*32 +: 32] = grant_q[i];
  end
`endif

endmodule
